// File: rtl/acq_track_if.sv
// acq_track_if: control/status bundle between the correlator channel
// logic and the acquisition/tracking sequencer.
//
// Strobe semantics: start and dump_strobe are single-cycle pulses with no
// back-pressure. power is only meaningful in the cycle dump_strobe is high.
// The sequencer never stalls a strobe; every pulse is consumed in the cycle
// it appears. code_slew is a single-cycle pulse from the sequencer asking the
// code NCO to retard by half a chip.
interface acq_track_if #(
  parameter int PWR_W = 29,
  parameter int BIN_W = 5
);
  logic             start;
  logic             dump_strobe;
  logic [PWR_W-1:0] power;
  logic [PWR_W-1:0] threshold;
  logic             code_slew;
  logic [BIN_W-1:0] dopp_bin;
  logic             loop_en;
  logic             locked;
  logic             acq_fail;
  logic [2:0]       state;
  logic [PWR_W-1:0] peak_power;
  logic [10:0]      peak_phase;

  // Channel side: issues start/strobes, consumes the sequencer controls.
  modport master (
    output start, dump_strobe, power, threshold,
    input  code_slew, dopp_bin, loop_en, locked, acq_fail, state,
           peak_power, peak_phase
  );

  // Sequencer side.
  modport slave (
    input  start, dump_strobe, power, threshold,
    output code_slew, dopp_bin, loop_en, locked, acq_fail, state,
           peak_power, peak_phase
  );
endinterface

// File: rtl/acq_track_ctrl.sv
// acq_track_ctrl: per-channel GPS acquisition/tracking sequencer.
//
// Serial search over half-chip code phases and Doppler bins, an M-of-N
// confirm window, a fixed pull-in period with the loops enabled, then lock
// monitoring in track with fall-back to a fresh search on loss of lock.
//
// Optional build macro: ACQ_PEAK_CAPTURE_EN
//   defined   -> peak_power/peak_phase record the strongest post-settle
//                search dump since the last start/reset.
//   undefined -> peak_power/peak_phase are constant zero.
module acq_track_ctrl #(
  parameter int PWR_W        = 29,
  parameter int CODE_STEPS   = 2046,
  parameter int NUM_BINS     = 21,
  parameter int SETTLE       = 1,
  parameter int CONF_N       = 4,
  parameter int CONF_M       = 3,
  parameter int PULLIN_DUMPS = 50,
  parameter int LOSS_CNT     = 8
) (
  input  logic        CLK,
  input  logic        RST,
  acq_track_if.slave  bus
);

  // Phase counter is sized to the peak_phase output (2046 hypotheses fit in 11 bits).
  localparam int PH_W  = 11;
  localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int SET_W = ($clog2(SETTLE + 1) < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int CNF_W = ($clog2(CONF_N + 1) < 1) ? 1 : $clog2(CONF_N + 1);
  localparam int PUL_W = ($clog2(PULLIN_DUMPS + 1) < 1) ? 1 : $clog2(PULLIN_DUMPS + 1);
  localparam int LOS_W = ($clog2(LOSS_CNT + 1) < 1) ? 1 : $clog2(LOSS_CNT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEARCH  = 3'd1,
    S_CONFIRM = 3'd2,
    S_PULLIN  = 3'd3,
    S_TRACK   = 3'd4,
    S_FAIL    = 3'd5
  } state_t;

  state_t           st;
  logic [PH_W-1:0]  phase;
  logic [BIN_W-1:0] bin;
  logic [SET_W-1:0] settle;
  logic [CNF_W-1:0] conf_cnt;
  logic [CNF_W-1:0] win_cnt;
  logic [PUL_W-1:0] pull_cnt;
  logic [LOS_W-1:0] loss_cnt;
  logic             code_slew_q;
  logic             loop_en_q;
  logic             locked_q;
  logic             acq_fail_q;

  logic             hit;
  logic             last_phase;
  logic             last_bin;
  logic             settle_dec;
  logic             search_eval;
  logic [CNF_W-1:0] conf_next;
  logic [CNF_W-1:0] win_next;

  // Detection decision and end-of-grid flags for the current hypothesis.
  always_comb begin
    hit         = bus.dump_strobe && (bus.power >= bus.threshold);
    last_phase  = (phase == PH_W'(CODE_STEPS - 1));
    last_bin    = (bin == BIN_W'(NUM_BINS - 1));
    // A strobe while settling only burns down the settle count.
    settle_dec  = (st == S_SEARCH) && bus.dump_strobe && (settle != '0);
    // A strobe right behind a slew is also treated as unsettled, so two
    // slews can never land on consecutive cycles even with SETTLE = 0.
    search_eval = (st == S_SEARCH) && bus.dump_strobe && (settle == '0) && !code_slew_q;
    conf_next   = conf_cnt + CNF_W'(hit);
    win_next    = win_cnt + CNF_W'(1);
  end

  // Sequencer FSM with all controls registered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st          <= S_IDLE;
      phase       <= '0;
      bin         <= '0;
      settle      <= '0;
      conf_cnt    <= '0;
      win_cnt     <= '0;
      pull_cnt    <= '0;
      loss_cnt    <= '0;
      code_slew_q <= 1'b0;
      loop_en_q   <= 1'b0;
      locked_q    <= 1'b0;
      acq_fail_q  <= 1'b0;
    end else begin
      code_slew_q <= 1'b0;
      case (st)
        // Start has priority over a coincident strobe; the strobe is dropped.
        S_IDLE, S_FAIL: begin
          if (bus.start) begin
            st         <= S_SEARCH;
            phase      <= '0;
            bin        <= '0;
            settle     <= SET_W'(SETTLE);
            conf_cnt   <= '0;
            win_cnt    <= '0;
            pull_cnt   <= '0;
            loss_cnt   <= '0;
            loop_en_q  <= 1'b0;
            locked_q   <= 1'b0;
            acq_fail_q <= 1'b0;
          end
        end

        S_SEARCH: begin
          if (settle_dec) begin
            settle <= settle - SET_W'(1);
          end else if (search_eval) begin
            if (hit) begin
              st       <= S_CONFIRM;
              conf_cnt <= CNF_W'(1);
              win_cnt  <= CNF_W'(1);
            end else if (last_phase && last_bin) begin
              st         <= S_FAIL;
              acq_fail_q <= 1'b1;
            end else if (last_phase) begin
              // Wrapping the code phase goes with a bin change, not a slew.
              phase  <= '0;
              bin    <= bin + BIN_W'(1);
              settle <= SET_W'(SETTLE);
            end else begin
              phase       <= phase + PH_W'(1);
              settle      <= SET_W'(SETTLE);
              code_slew_q <= 1'b1;
            end
          end
        end

        // M-of-N window; success is allowed before the window closes.
        S_CONFIRM: begin
          if (bus.dump_strobe) begin
            if (conf_next >= CNF_W'(CONF_M)) begin
              st        <= S_PULLIN;
              pull_cnt  <= '0;
              loop_en_q <= 1'b1;
            end else if (win_next >= CNF_W'(CONF_N)) begin
              // Rejected: move on exactly as a search miss would.
              conf_cnt <= '0;
              win_cnt  <= '0;
              if (last_phase && last_bin) begin
                st         <= S_FAIL;
                acq_fail_q <= 1'b1;
              end else if (last_phase) begin
                st     <= S_SEARCH;
                phase  <= '0;
                bin    <= bin + BIN_W'(1);
                settle <= SET_W'(SETTLE);
              end else begin
                st          <= S_SEARCH;
                phase       <= phase + PH_W'(1);
                settle      <= SET_W'(SETTLE);
                code_slew_q <= 1'b1;
              end
            end else begin
              conf_cnt <= conf_next;
              win_cnt  <= win_next;
            end
          end
        end

        // Loops run for a fixed number of dumps regardless of power.
        S_PULLIN: begin
          if (bus.dump_strobe) begin
            if (pull_cnt == PUL_W'(PULLIN_DUMPS - 1)) begin
              st       <= S_TRACK;
              locked_q <= 1'b1;
              loss_cnt <= '0;
            end else begin
              pull_cnt <= pull_cnt + PUL_W'(1);
            end
          end
        end

        // Consecutive misses declare loss of lock; any hit restarts the run.
        S_TRACK: begin
          if (bus.dump_strobe) begin
            if (hit) begin
              loss_cnt <= '0;
            end else if (loss_cnt == LOS_W'(LOSS_CNT - 1)) begin
              st        <= S_SEARCH;
              phase     <= '0;
              bin       <= '0;
              settle    <= SET_W'(SETTLE);
              loss_cnt  <= '0;
              loop_en_q <= 1'b0;
              locked_q  <= 1'b0;
            end else begin
              loss_cnt <= loss_cnt + LOS_W'(1);
            end
          end
        end

        default: begin
          st <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.code_slew = code_slew_q;
  assign bus.dopp_bin  = bin;
  assign bus.loop_en   = loop_en_q;
  assign bus.locked    = locked_q;
  assign bus.acq_fail  = acq_fail_q;
  assign bus.state     = st;

`ifdef ACQ_PEAK_CAPTURE_EN
  logic [PWR_W-1:0] peak_power_q;
  logic [PH_W-1:0]  peak_phase_q;

  // Strongest evaluated search dump since the last start; held elsewhere.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      peak_power_q <= '0;
      peak_phase_q <= '0;
    end else if (((st == S_IDLE) || (st == S_FAIL)) && bus.start) begin
      peak_power_q <= '0;
      peak_phase_q <= '0;
    end else if (search_eval && (bus.power > peak_power_q)) begin
      peak_power_q <= bus.power;
      peak_phase_q <= phase;
    end
  end

  assign bus.peak_power = peak_power_q;
  assign bus.peak_phase = peak_phase_q;
`else
  assign bus.peak_power = '0;
  assign bus.peak_phase = '0;
`endif

  // A slew is one cycle wide and always leaves the sequencer searching.
  a_slew_single : assert property (@(posedge CLK) disable iff (!RST)
    code_slew_q |=> !code_slew_q);
  a_slew_search : assert property (@(posedge CLK) disable iff (!RST)
    code_slew_q |-> (st == S_SEARCH));
  // Lock is only ever reported with the loops closed.
  a_lock_loops  : assert property (@(posedge CLK) disable iff (!RST)
    locked_q |-> loop_en_q);

endmodule

// File: tb/tb_acq_track_ctrl.sv
// tb_acq_track_ctrl: bench for acq_track_ctrl with a reduced search grid.
// The reference model walks a flat hypothesis index (bin * CODE_STEPS + phase)
// and keeps the confirm window as a queue of hit flags.
module tb_acq_track_ctrl;

  localparam int PWR_W        = 29;
  localparam int CODE_STEPS   = 8;
  localparam int NUM_BINS     = 3;
  localparam int SETTLE       = 1;
  localparam int CONF_N       = 4;
  localparam int CONF_M       = 3;
  localparam int PULLIN_DUMPS = 5;
  localparam int LOSS_CNT     = 3;
  localparam int BIN_W        = $clog2(NUM_BINS);

  localparam int M_IDLE = 0, M_SEARCH = 1, M_CONFIRM = 2, M_PULLIN = 3, M_TRACK = 4, M_FAIL = 5;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  acq_track_if #(.PWR_W(PWR_W), .BIN_W(BIN_W)) bus ();

  acq_track_ctrl #(
    .PWR_W(PWR_W), .CODE_STEPS(CODE_STEPS), .NUM_BINS(NUM_BINS), .SETTLE(SETTLE),
    .CONF_N(CONF_N), .CONF_M(CONF_M), .PULLIN_DUMPS(PULLIN_DUMPS), .LOSS_CNT(LOSS_CNT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int          m_state;
  int          m_idx;
  int          m_settle;
  int          m_pull;
  int          m_miss_run;
  bit          m_slew;
  bit          m_conf_q[$];
  int unsigned m_peak_pwr;
  int          m_peak_ph;
  int unsigned thr;

  function automatic void model_reset();
    m_state = M_IDLE; m_idx = 0; m_settle = 0; m_pull = 0; m_miss_run = 0;
    m_slew = 1'b0; m_conf_q.delete(); m_peak_pwr = 0; m_peak_ph = 0;
  endfunction

  function automatic void model_start();
    m_slew = 1'b0;
    if (m_state == M_IDLE || m_state == M_FAIL) begin
      m_state = M_SEARCH; m_idx = 0; m_settle = SETTLE;
      m_peak_pwr = 0; m_peak_ph = 0;
    end
  endfunction

  function automatic void model_next_hypothesis();
    if (m_idx + 1 == CODE_STEPS * NUM_BINS) begin
      m_state = M_FAIL;
    end else begin
      m_idx++;
      m_state = M_SEARCH;
      m_settle = SETTLE;
      m_slew = ((m_idx % CODE_STEPS) != 0);
    end
  endfunction

  function automatic void model_strobe(input int unsigned p);
    bit hit;
    int nh;
    hit = (p >= thr);
    m_slew = 1'b0;
    case (m_state)
      M_SEARCH: begin
        if (m_settle > 0) begin
          m_settle--;
        end else begin
          if (p > m_peak_pwr) begin
            m_peak_pwr = p;
            m_peak_ph = m_idx % CODE_STEPS;
          end
          if (hit) begin
            m_state = M_CONFIRM;
            m_conf_q.delete();
            m_conf_q.push_back(1'b1);
          end else begin
            model_next_hypothesis();
          end
        end
      end
      M_CONFIRM: begin
        m_conf_q.push_back(hit);
        nh = 0;
        foreach (m_conf_q[k]) nh += int'(m_conf_q[k]);
        if (nh >= CONF_M) begin
          m_state = M_PULLIN;
          m_pull = 0;
        end else if (m_conf_q.size() >= CONF_N) begin
          model_next_hypothesis();
        end
      end
      M_PULLIN: begin
        m_pull++;
        if (m_pull == PULLIN_DUMPS) begin
          m_state = M_TRACK;
          m_miss_run = 0;
        end
      end
      M_TRACK: begin
        if (hit) m_miss_run = 0;
        else m_miss_run++;
        if (m_miss_run == LOSS_CNT) begin
          m_state = M_SEARCH; m_idx = 0; m_settle = SETTLE; m_miss_run = 0;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [2:0] e_state();
    return 3'(m_state);
  endfunction
  function automatic logic [BIN_W-1:0] e_bin();
    return BIN_W'(m_idx / CODE_STEPS);
  endfunction
  function automatic logic e_loop();
    return (m_state == M_PULLIN || m_state == M_TRACK);
  endfunction
  function automatic logic e_lock();
    return (m_state == M_TRACK);
  endfunction
  function automatic logic e_fail();
    return (m_state == M_FAIL);
  endfunction
  function automatic logic [PWR_W-1:0] e_ppwr();
`ifdef ACQ_PEAK_CAPTURE_EN
    return PWR_W'(m_peak_pwr);
`else
    return '0;
`endif
  endfunction
  function automatic logic [10:0] e_pph();
`ifdef ACQ_PEAK_CAPTURE_EN
    return 11'(m_peak_ph);
`else
    return '0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    RST = 1'b0;
    bus.start = 1'b0; bus.dump_strobe = 1'b0; bus.power = '0; bus.threshold = '0;
    thr = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic set_thr(input int unsigned v);
    thr = v;
    bus.threshold = PWR_W'(v);
  endtask

  // One strobe; gap=1 inserts an idle cycle first. Returns 1 time unit after the edge.
  task automatic strobe(input int unsigned p, input bit gap);
    if (gap) begin
      @(negedge CLK);
      bus.dump_strobe = 1'b0;
    end
    @(negedge CLK);
    bus.dump_strobe = 1'b1;
    bus.power = PWR_W'(p);
    model_strobe(p);
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    @(negedge CLK);
    bus.dump_strobe = 1'b0;
  endtask

  task automatic pulse_start(input bit with_strobe, input int unsigned p);
    @(negedge CLK);
    bus.start = 1'b1;
    bus.dump_strobe = with_strobe;
    bus.power = PWR_W'(p);
    model_start();
    @(posedge CLK);
    #1;
    @(negedge CLK);
    bus.start = 1'b0;
    bus.dump_strobe = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    checks++; if (bus.code_slew !== 1'b0) begin errors++; $display("FAIL reset_slew: got %b want 0", bus.code_slew); end
    checks++; if (bus.dopp_bin !== '0) begin errors++; $display("FAIL reset_bin: got %0d want 0", bus.dopp_bin); end
    checks++; if (bus.loop_en !== 1'b0) begin errors++; $display("FAIL reset_loop_en: got %b want 0", bus.loop_en); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
    checks++; if (bus.acq_fail !== 1'b0) begin errors++; $display("FAIL reset_acq_fail: got %b want 0", bus.acq_fail); end
    checks++; if (bus.peak_power !== '0) begin errors++; $display("FAIL reset_peak_power: got %0d want 0", bus.peak_power); end
    checks++; if (bus.peak_phase !== '0) begin errors++; $display("FAIL reset_peak_phase: got %0d want 0", bus.peak_phase); end
  endtask

  // Start and strobe together in IDLE: start wins, settle is still loaded.
  task automatic test_start_with_strobe();
    set_thr(0);
    pulse_start(1'b1, 5);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL start_strobe_state: got %0d want 1", bus.state); end
    strobe(7, 1'b1);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL start_strobe_settle: got %0d want 1", bus.state); end
    strobe(7, 1'b1);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL start_strobe_detect: got %0d want 2", bus.state); end
    quiet();
    apply_reset();
  endtask

  task automatic test_all_miss();
    int slews[3] = '{0, 0, 0};
    int fail_at = -1;
    int b;
    set_thr(1000);
    pulse_start(1'b0, 0);
    for (int i = 1; i <= 48; i++) begin
      strobe($urandom_range(0, 999), 1'b1);
      checks++; if (bus.state !== e_state()) begin errors++; $display("FAIL miss_state[%0d]: got %0d want %0d", i, bus.state, e_state()); end
      checks++; if (bus.dopp_bin !== e_bin()) begin errors++; $display("FAIL miss_bin[%0d]: got %0d want %0d", i, bus.dopp_bin, e_bin()); end
      checks++; if (bus.code_slew !== m_slew) begin errors++; $display("FAIL miss_slew[%0d]: got %b want %b", i, bus.code_slew, m_slew); end
      b = int'(bus.dopp_bin);
      if (bus.code_slew === 1'b1 && b < 3) slews[b]++;
      if (fail_at < 0 && bus.state === 3'd5) fail_at = i;
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (slews[k] != CODE_STEPS - 1) begin errors++; $display("FAIL miss_slew_count[bin %0d]: got %0d want %0d", k, slews[k], CODE_STEPS - 1); end
    end
    checks++; if (fail_at != 48) begin errors++; $display("FAIL miss_fail_strobe: got %0d want 48", fail_at); end
    checks++; if (bus.acq_fail !== 1'b1) begin errors++; $display("FAIL miss_acq_fail: got %b want 1", bus.acq_fail); end
    checks++; if (bus.loop_en !== 1'b0) begin errors++; $display("FAIL miss_loop_en: got %b want 0", bus.loop_en); end
    checks++; if (bus.peak_power !== e_ppwr()) begin errors++; $display("FAIL miss_peak_power: got %0d want %0d", bus.peak_power, e_ppwr()); end
    strobe(2000, 1'b1);
    checks++; if (bus.state !== 3'd5) begin errors++; $display("FAIL fail_holds: got %0d want 5", bus.state); end
    quiet();
  endtask

  task automatic test_peak();
    int unsigned pw[6] = '{500, 5, 500, 90, 500, 40};
    logic [PWR_W-1:0] want_pwr;
    logic [10:0]      want_ph;
`ifdef ACQ_PEAK_CAPTURE_EN
    want_pwr = PWR_W'(90); want_ph = 11'd1;
`else
    want_pwr = '0; want_ph = '0;
`endif
    pulse_start(1'b0, 0);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL peak_restart_state: got %0d want 1", bus.state); end
    checks++; if (bus.acq_fail !== 1'b0) begin errors++; $display("FAIL peak_restart_acq_fail: got %b want 0", bus.acq_fail); end
    checks++; if (bus.peak_power !== '0) begin errors++; $display("FAIL peak_cleared: got %0d want 0", bus.peak_power); end
    for (int i = 0; i < 6; i++) strobe(pw[i], 1'b1);
    checks++; if (bus.peak_power !== want_pwr) begin errors++; $display("FAIL peak_power: got %0d want %0d", bus.peak_power, want_pwr); end
    checks++; if (bus.peak_phase !== want_ph) begin errors++; $display("FAIL peak_phase: got %0d want %0d", bus.peak_phase, want_ph); end
    quiet();
  endtask

  task automatic test_detect();
    int n = 0;
    int unsigned p;
    apply_reset();
    set_thr(1000);
    pulse_start(1'b0, 0);
    while (m_state != M_CONFIRM && n < 200) begin
      p = (m_idx == CODE_STEPS + 5) ? 2000 : $urandom_range(0, 999);
      strobe(p, 1'b1);
      n++;
      checks++; if (bus.state !== e_state()) begin errors++; $display("FAIL detect_state[%0d]: got %0d want %0d", n, bus.state, e_state()); end
      checks++; if (bus.dopp_bin !== e_bin()) begin errors++; $display("FAIL detect_bin[%0d]: got %0d want %0d", n, bus.dopp_bin, e_bin()); end
    end
    checks++; if (n != 28) begin errors++; $display("FAIL detect_strobes: got %0d want 28", n); end
    checks++; if (bus.dopp_bin !== BIN_W'(1)) begin errors++; $display("FAIL detect_bin_final: got %0d want 1", bus.dopp_bin); end
    strobe(1000, 1'b1);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL confirm_hit2: got %0d want 2", bus.state); end
    strobe(2000, 1'b1);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL confirm_to_pullin: got %0d want 3", bus.state); end
    checks++; if (bus.loop_en !== 1'b1) begin errors++; $display("FAIL pullin_loop_en: got %b want 1", bus.loop_en); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL pullin_locked: got %b want 0", bus.locked); end
    for (int k = 1; k <= 5; k++) begin
      strobe($urandom_range(0, 2000), 1'b1);
      checks++; if (bus.state !== ((k < 5) ? 3'd3 : 3'd4)) begin errors++; $display("FAIL pullin_state[%0d]: got %0d want %0d", k, bus.state, (k < 5) ? 3 : 4); end
    end
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL track_locked: got %b want 1", bus.locked); end
    checks++; if (bus.loop_en !== 1'b1) begin errors++; $display("FAIL track_loop_en: got %b want 1", bus.loop_en); end
    quiet();
  endtask

  task automatic test_loss();
    bit    pat[6]    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] want[6] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd1};
    for (int i = 0; i < 6; i++) begin
      strobe(pat[i] ? $urandom_range(1000, 3000) : $urandom_range(0, 999), 1'b1);
      checks++; if (bus.state !== want[i]) begin errors++; $display("FAIL loss_state[%0d]: got %0d want %0d", i, bus.state, want[i]); end
    end
    checks++; if (bus.dopp_bin !== '0) begin errors++; $display("FAIL loss_bin: got %0d want 0", bus.dopp_bin); end
    checks++; if (bus.loop_en !== 1'b0) begin errors++; $display("FAIL loss_loop_en: got %b want 0", bus.loop_en); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL loss_locked: got %b want 0", bus.locked); end
    // Phase restarted at 0: the bin only advances after a full 16-strobe sweep.
    for (int i = 1; i <= 16; i++) begin
      strobe($urandom_range(0, 999), 1'b1);
      checks++; if (bus.dopp_bin !== e_bin()) begin errors++; $display("FAIL loss_resweep_bin[%0d]: got %0d want %0d", i, bus.dopp_bin, e_bin()); end
    end
    quiet();
  endtask

  task automatic test_confirm_reject();
    int n = 0;
    apply_reset();
    set_thr(1000);
    pulse_start(1'b0, 0);
    while (m_state != M_CONFIRM && n < 50) begin
      strobe((m_idx == 2) ? 2000 : $urandom_range(0, 999), 1'b1);
      n++;
    end
    checks++; if (n != 6 || bus.state !== 3'd2) begin errors++; $display("FAIL reject_enter: got strobes %0d state %0d want 6 and 2", n, bus.state); end
    pulse_start(1'b0, 0);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL start_ignored: got %0d want 2", bus.state); end
    strobe(2000, 1'b1);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL reject_win2: got %0d want 2", bus.state); end
    strobe(10, 1'b1);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL reject_win3: got %0d want 2", bus.state); end
    strobe(10, 1'b1);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL reject_state: got %0d want 1", bus.state); end
    checks++; if (bus.code_slew !== 1'b1) begin errors++; $display("FAIL reject_slew: got %b want 1", bus.code_slew); end
    checks++; if (bus.dopp_bin !== '0) begin errors++; $display("FAIL reject_bin: got %0d want 0", bus.dopp_bin); end
    // Resumed at phase 3: five phases (10 strobes) remain before the bin steps.
    for (int i = 1; i <= 10; i++) begin
      strobe($urandom_range(0, 999), 1'b1);
      checks++; if (bus.dopp_bin !== ((i == 10) ? BIN_W'(1) : BIN_W'(0))) begin errors++; $display("FAIL reject_resume_bin[%0d]: got %0d want %0d", i, bus.dopp_bin, (i == 10) ? 1 : 0); end
    end
    quiet();
  endtask

  task automatic test_reset_mid_track();
    int n = 0;
    apply_reset();
    set_thr(0);
    pulse_start(1'b0, 0);
    while (m_state != M_TRACK && n < 30) begin
      strobe($urandom_range(0, 3000), 1'b1);
      n++;
    end
    checks++; if (bus.state !== 3'd4 || bus.locked !== 1'b1) begin errors++; $display("FAIL mid_track_reach: got state %0d locked %b want 4 and 1", bus.state, bus.locked); end
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL async_reset_state: got %0d want 0", bus.state); end
    checks++; if (bus.loop_en !== 1'b0) begin errors++; $display("FAIL async_reset_loop_en: got %b want 0", bus.loop_en); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL async_reset_locked: got %b want 0", bus.locked); end
    model_reset();
    bus.dump_strobe = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit prev_slew = 1'b0;
    set_thr($urandom_range(300, 700));
    pulse_start(1'b0, 0);
    for (int i = 0; i < 400; i++) begin
      if (m_state == M_IDLE || m_state == M_FAIL || $urandom_range(0, 39) == 0) begin
        pulse_start(1'b0, 0);
        prev_slew = 1'b0;
        checks++; if (bus.state !== e_state()) begin errors++; $display("FAIL b2b_start_state[%0d]: got %0d want %0d", i, bus.state, e_state()); end
      end else begin
        strobe($urandom_range(0, 1000), 1'b0);
        checks++; if (bus.state !== e_state()) begin errors++; $display("FAIL b2b_state[%0d]: got %0d want %0d", i, bus.state, e_state()); end
        checks++; if (bus.dopp_bin !== e_bin()) begin errors++; $display("FAIL b2b_bin[%0d]: got %0d want %0d", i, bus.dopp_bin, e_bin()); end
        checks++; if (bus.code_slew !== m_slew) begin errors++; $display("FAIL b2b_slew[%0d]: got %b want %b", i, bus.code_slew, m_slew); end
        checks++; if (bus.loop_en !== e_loop()) begin errors++; $display("FAIL b2b_loop_en[%0d]: got %b want %b", i, bus.loop_en, e_loop()); end
        checks++; if (bus.locked !== e_lock()) begin errors++; $display("FAIL b2b_locked[%0d]: got %b want %b", i, bus.locked, e_lock()); end
        checks++; if (bus.acq_fail !== e_fail()) begin errors++; $display("FAIL b2b_acq_fail[%0d]: got %b want %b", i, bus.acq_fail, e_fail()); end
        checks++; if (bus.peak_power !== e_ppwr() || bus.peak_phase !== e_pph()) begin errors++; $display("FAIL b2b_peak[%0d]: got %0d@%0d want %0d@%0d", i, bus.peak_power, bus.peak_phase, e_ppwr(), e_pph()); end
        checks++; if (prev_slew && bus.code_slew === 1'b1) begin errors++; $display("FAIL b2b_slew_pair[%0d]: got two consecutive slews want one", i); end
        prev_slew = bus.code_slew;
      end
    end
    quiet();
  endtask

  // Bound on total run time in case the DUT wedges the bench.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    test_reset();
    test_start_with_strobe();
    test_all_miss();
    test_peak();
    test_detect();
    test_loss();
    test_confirm_reject();
    test_reset_mid_track();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acq_track_ctrl.md
Name: acq_track_ctrl

Overview:
Per-channel acquisition/tracking sequencer for the GPS correlator channel. It runs a serial search over code phase (half-chip steps) and Doppler bins using the accumulated correlator power, then confirms a detection and enables the DLL and Costas loop corrections. In track it monitors lock and returns to search on loss. It sits beside the correlators and drives the code NCO slew, carrier Doppler bin select and loop-enable controls.

Parameters:
PWR_W, 29, width of power input and threshold
CODE_STEPS, 2046, half-chip hypotheses per Doppler bin (2 x 1023 chips)
NUM_BINS, 21, Doppler bins searched; bin NUM_BINS/2 is zero Doppler
SETTLE, 1, dumps discarded after each slew or bin change
CONF_N, 4, dumps in confirm window
CONF_M, 3, above-threshold dumps required to confirm
PULLIN_DUMPS, 50, dumps with loops enabled before declaring lock
LOSS_CNT, 8, consecutive below-threshold dumps that cause loss of lock

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins search from phase 0, bin 0
dump_strobe  in  1  one-cycle pulse in CLK domain at end of each accumulation period
power  in  PWR_W  punctual-equivalent power (early+late sum), valid while dump_strobe=1
threshold  in  PWR_W  detection threshold, unsigned
code_slew  out  1  one-cycle pulse; code NCO retards by half a chip
dopp_bin  out  clog2(NUM_BINS)  Doppler bin select for carrier NCO
loop_en  out  1  enables DLL and Costas corrections
locked  out  1  high in TRACK only
acq_fail  out  1  high in FAIL until next start
state  out  3  IDLE=0, SEARCH=1, CONFIRM=2, PULLIN=3, TRACK=4, FAIL=5
peak_power  out  PWR_W  optional-feature output
peak_phase  out  11  optional-feature output

Behaviour:
- Reset (RST low, async): state=IDLE; all outputs, phase counter, bin counter, settle/confirm/loss counters = 0.
- "hit" = dump_strobe & (power >= threshold), unsigned compare. All decisions are registered; outputs change on the CLK edge after the strobe.
- IDLE/FAIL: start -> SEARCH, phase=0, bin=0, settle=SETTLE, acq_fail cleared. start in any other state is ignored. In IDLE, start and dump_strobe in the same cycle: start wins and the strobe is ignored.
- SEARCH: while settle>0, each strobe decrements settle and the power is ignored. After settle: hit -> CONFIRM (conf_cnt=1, win=1). Non-hit strobe -> code_slew pulse, phase+1, settle=SETTLE. When phase reaches CODE_STEPS-1 and misses: phase=0, bin+1, no slew. When bin reaches NUM_BINS-1, phase reaches CODE_STEPS-1 and it misses -> FAIL.
- CONFIRM: each strobe increments win; hit increments conf_cnt. conf_cnt reaches CONF_M -> PULLIN (early exit allowed). win reaches CONF_N without success -> back to SEARCH, with the same increment/slew rule as a SEARCH miss.
- PULLIN: loop_en=1; counts PULLIN_DUMPS strobes regardless of power -> TRACK.
- TRACK: loop_en=1, locked=1. Non-hit strobe increments loss; hit clears loss. loss reaches LOSS_CNT -> SEARCH with phase=0, bin=0, loop_en=0, locked=0.
- FAIL: acq_fail=1, loop_en=0; holds until start.
- code_slew is never asserted outside SEARCH/CONFIRM and never on two consecutive cycles.
- dopp_bin = bin counter, registered.

Optional Feature:
Macro: ACQ_PEAK_CAPTURE_EN.
- Defined: during SEARCH (post-settle strobes), if power > peak_power, latch peak_power=power and peak_phase=phase. Values clear on start or reset and hold through the other states.
- Undefined: peak_power and peak_phase tied to 0, with no registers inferred.

Test Plan:
(Bench params for all scenarios: CODE_STEPS=8, NUM_BINS=3, SETTLE=1, CONF_N=4, CONF_M=3, PULLIN_DUMPS=5, LOSS_CNT=3.)
- Reset mid-TRACK: drop RST asynchronously -> state=0, loop_en=0, locked=0 in the same cycle, without waiting for an edge.
- All-miss search: threshold=1000, power=10 on every strobe -> 7 slews per bin, dopp_bin steps 0->1->2, then state=FAIL and acq_fail=1 after 3*8*2=48 strobes.
- Detect at phase 5, bin 1: power=2000 only when phase=5 and bin=1; otherwise 10 -> CONFIRM. Three hits -> PULLIN; after 5 more strobes -> TRACK with locked=1.
- Confirm reject: 2 of 4 hits in CONFIRM -> returns to SEARCH with a code_slew pulse and phase+1.
- Loss: in TRACK, strobes miss, miss, hit, miss, miss, miss -> stays in TRACK until the third consecutive miss, then SEARCH with phase=0 and bin=0.
- ACQ_PEAK_CAPTURE_EN: search powers 5, 90, 40 at phases 0-2 -> peak_power=90, peak_phase=1. With the macro undefined, both outputs read 0.
